// File: rtl/mult_div.sv
// HI/LO multiply-divide unit with fixed-latency busy window.
// Results are computed combinationally from latched operands and written to HI/LO on the final busy edge.
module mult_div #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        o_dbg_state
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Start/Busy handshake: Start is a one-cycle request sampled only while Busy=0;
  // requests seen while Busy=1 are dropped, never queued.
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_accept, w_done;

  logic [31:0]   r_a, r_b, r_hi, r_lo;
  logic [1:0]    r_op;

  logic [63:0]   w_a_sx, w_b_sx, w_prod_s, w_prod_u;
  logic          w_signed;
  logic [31:0]   w_dvd, w_dvs, w_q, w_r, w_quo, w_rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start && !MDOp[2]) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
          w_cnt_nxt   = MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else if (w_accept) begin
      r_a  <= A;
      r_b  <= B;
      r_op <= MDOp[1:0];
    end
  end

  assign w_a_sx   = {{32{r_a[31]}}, r_a};
  assign w_b_sx   = {{32{r_b[31]}}, r_b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed divide runs on magnitudes, then restores signs; 0x80000000 / -1 wraps to 0x80000000.
  assign w_signed = (r_op == 2'd2);
  assign w_dvd    = (w_signed && r_a[31]) ? (~r_a + 32'd1) : r_a;
  assign w_dvs    = (w_signed && r_b[31]) ? (~r_b + 32'd1) : r_b;
  assign w_q      = (w_dvs == 32'd0) ? 32'd0 : (w_dvd / w_dvs);
  assign w_r      = (w_dvs == 32'd0) ? 32'd0 : (w_dvd % w_dvs);
  assign w_quo    = (w_signed && (r_a[31] ^ r_b[31])) ? (~w_q + 32'd1) : w_q;
  assign w_rem    = (w_signed && r_a[31]) ? (~w_r + 32'd1) : w_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      case (r_op)
        2'd0: {r_hi, r_lo} <= w_prod_s;
        2'd1: {r_hi, r_lo} <= w_prod_u;
        default: begin
          if (r_b != 32'd0) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
      endcase
    end else if (r_state == S_IDLE && Start) begin
      if (MDOp == 3'd4) r_hi <= A;
      if (MDOp == 3'd5) r_lo <= A;
    end
  end

  assign Busy        = (r_state == S_RUN);
  assign HI          = r_hi;
  assign LO          = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div.sv
// Bench for mult_div: directed vector table, hand-built corner sequences, and random ops against a reference model.
module tb_mult_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;
  logic        dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int busy_seen = 0;

  logic [31:0] exp_q[$];

  mult_div #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .Busy(Busy), .HI(HI), .LO(LO), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Busy width is measured as the number of low clock phases seen with Busy high.
  always @(negedge clk) if (Busy) busy_seen <= busy_seen + 1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo;
    int          exp_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int exp_busy_of(input logic [2:0] op);
    if (op <= 3'd1) return 5;
    if (op <= 3'd3) return 10;
    return 0;
  endfunction

  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    inout logic [31:0] hi, inout logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; lo = 32'(q); hi = 32'(r); end
      3'd3: if (b != 0) begin lo = a / b; hi = a % b; end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endfunction

  // Issue one op, scramble inputs after acceptance, wait (bounded) for Busy to drop.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busy_n, output logic hold_ok);
    logic [31:0] h0, l0;
    int base, t;
    @(negedge clk);
    h0 = HI; l0 = LO; base = busy_seen;
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0; A = $urandom; B = $urandom; MDOp = 3'($urandom);
    hold_ok = 1'b1;
    t = 0;
    while (Busy && t < 100) begin
      if (HI !== h0 || LO !== l0) hold_ok = 1'b0;
      @(posedge clk); #1;
      t++;
    end
    busy_n = busy_seen - base;
  endtask

  initial begin
    int bn, base, t;
    logic hok;
    logic [31:0] m_hi, m_lo, e_hi, e_lo, e_b;
    logic [2:0] op;
    logic [31:0] a, b;

    vecs[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'd3, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{3'd4, 32'hAAAA5555, 32'd0,        32'hAAAA5555, 32'h80000000, 0};
    vecs[6] = '{3'd5, 32'h0000FFFF, 32'd0,        32'hAAAA5555, 32'h0000FFFF, 0};
    vecs[7] = '{3'd6, 32'h12345678, 32'd9,        32'hAAAA5555, 32'h0000FFFF, 0};
    vecs[8] = '{3'd7, 32'h87654321, 32'd9,        32'hAAAA5555, 32'h0000FFFF, 0};
    vecs[9] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};

    reset = 1'b1; Start = 1'b0; MDOp = '0; A = '0; B = '0;
    #12;
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, bn, hok);
      check($sformatf("vec%0d_busy", i), 32'(bn), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_hi", i), HI, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), LO, vecs[i].exp_lo);
      check($sformatf("vec%0d_hold", i), {31'd0, hok}, 32'd1);
    end

    // Start pulses during a divide must be dropped: 100 / 7 -> q 14, r 2
    @(negedge clk);
    base = busy_seen;
    Start = 1'b1; MDOp = 3'd2; A = 32'd100; B = 32'd7;
    @(negedge clk); MDOp = 3'd5; A = 32'h1234;
    @(negedge clk); MDOp = 3'd0; A = 32'd3; B = 32'd4;
    @(negedge clk); Start = 1'b0;
    t = 0;
    while (Busy && t < 100) begin @(posedge clk); #1; t++; end
    check("ign_busy", 32'(busy_seen - base), 32'd10);
    check("ign_hi", HI, 32'd2);
    check("ign_lo", LO, 32'd14);

    // Randomized ops scored against the reference model
    m_hi = HI; m_lo = LO;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      ref_model(op, a, b, m_hi, m_lo);
      exp_q.push_back(m_hi);
      exp_q.push_back(m_lo);
      exp_q.push_back(32'(exp_busy_of(op)));
      do_op(op, a, b, bn, hok);
      e_hi = exp_q.pop_front();
      e_lo = exp_q.pop_front();
      e_b  = exp_q.pop_front();
      check($sformatf("rnd%0d_op%0d_busy", i, op), 32'(bn), e_b);
      check($sformatf("rnd%0d_op%0d_hi", i, op), HI, e_hi);
      check($sformatf("rnd%0d_op%0d_lo", i, op), LO, e_lo);
      check($sformatf("rnd%0d_hold", i), {31'd0, hok}, 32'd1);
    end

    // Ensure HI/LO are nonzero so the reset clear is observable
    do_op(3'd4, 32'hDEADBEEF, 32'd0, bn, hok);
    do_op(3'd5, 32'hCAFEF00D, 32'd0, bn, hok);

    // Asynchronous reset three cycles into a multiply, between edges
    @(negedge clk);
    Start = 1'b1; MDOp = 3'd0; A = 32'd5; B = 32'd5;
    @(posedge clk); #1; Start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, Busy}, 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    do_op(3'd0, 32'd6, 32'd7, bn, hok);
    check("post_rst_busy", 32'(bn), 32'd5);
    check("post_rst_hi", HI, 32'd0);
    check("post_rst_lo", LO, 32'd42);
    check("post_rst_hold", {31'd0, hok}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 Start  input  1  qualifies MDOp for one cycle.
REQ-006 MDOp  input  3  operation code:
- 0 mult
- 1 multu
- 2 div
- 3 divu
- 4 mthi
- 5 mtlo
- 6, 7 reserved
REQ-007 A  input  32  operand rs / dividend / mthi-mtlo source.
REQ-008 B  input  32  operand rt / divisor.
REQ-009 Busy  output  1  high while an operation is in flight.
REQ-010 HI  output  32  HI register, registered output.
REQ-011 LO  output  32  LO register, registered output.

Function
REQ-012 States SHALL be IDLE and RUN; a down-counter of width ceil(log2(DIV_CYCLES+1)) SHALL track remaining cycles.
REQ-013 In IDLE, Start=1 with MDOp 0-3 SHALL be accepted at that edge:
- A, B and MDOp latched.
- Counter loaded with MULT_CYCLES or DIV_CYCLES.
- State moves to RUN.
REQ-014 Busy SHALL equal (state==RUN); it rises at the accepting edge, so an accept at edge T0 gives Busy=1 for exactly N cycles.
REQ-015 In RUN, the counter SHALL decrement each edge.
REQ-016 At the edge where the counter goes 1->0, the following SHALL happen at that same edge:
- HI/LO written with the result.
- State returns to IDLE.
- Busy falls.
REQ-017 New HI/LO SHALL be visible on the outputs the cycle after Busy falls, and SHALL NOT change earlier.
REQ-018 Start SHALL be ignored while Busy=1, for all MDOp values; the in-flight operation and its latched operands SHALL be unaffected.
REQ-019 In IDLE, Start=1 with MDOp=4 SHALL load HI<=A at that edge; MDOp=5 SHALL load LO<=A; Busy SHALL stay 0.
REQ-020 MDOp 6/7 with Start SHALL produce no state change.
REQ-021 mult: {HI,LO} SHALL be the signed 64-bit product of the latched A and B.
REQ-022 multu: {HI,LO} SHALL be the unsigned 64-bit product of the latched A and B.
REQ-023 div SHALL be signed:
- LO = quotient, truncated toward zero.
- HI = remainder, taking the sign of the dividend.
REQ-024 divu: LO SHALL be the unsigned quotient and HI the unsigned remainder.
REQ-025 Divisor 0 (div or divu): the full DIV_CYCLES Busy period SHALL occur, and HI/LO SHALL retain their prior values.
REQ-026 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000, with no trap or flag.
REQ-027 Operand changes on A/B after acceptance SHALL NOT affect the result.
REQ-028 Arithmetic MAY be combinational at completion or iterative, provided REQ-014..017 timing holds exactly.

Reset
REQ-029 reset=1 SHALL immediately, without waiting for clk, force:
- HI=0, LO=0.
- Busy=0.
- state=IDLE.
- counter=0.
REQ-030 reset asserted mid-operation SHALL abort the operation; no HI/LO write follows after reset release.
REQ-031 On the first edge after reset deasserts, Start SHALL be accepted normally.

Verification
REQ-032 Multiply timing and values:
- mult A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-033 Divide values and zero divisor:
- div A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=7, B=0 -> Busy high 10 cycles; HI/LO unchanged.
REQ-034 Ignored Start while busy: during a div, pulse Start with mtlo A=0x1234 and also mult -> both ignored; the final HI/LO are the div result.
REQ-035 mthi/mtlo in IDLE: mthi A=0xAAAA5555 then mtlo A=0x0000FFFF on consecutive cycles -> HI=0xAAAA5555, LO=0x0000FFFF, Busy never asserted.
REQ-036 Asynchronous reset mid-operation: assert reset 3 cycles into a mult, between clock edges -> Busy=0, HI=LO=0 immediately; after release, a mult 6x7 yields LO=42, HI=0.
REQ-037 Overflow divide: div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
